// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter with a single registered output stage.
// Writes to register 31 are acknowledged immediately and never reach the port.
module regwrite_arbiter #(
    parameter int FAIR         = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        AValid,
    output logic        AReady,
    input  logic [4:0]  ARW,
    input  logic [63:0] ABusW,
    input  logic        BValid,
    output logic        BReady,
    input  logic [4:0]  BRW,
    input  logic [63:0] BBusW,
    output logic        RegWr,
    output logic [4:0]  RW,
    output logic [63:0] BusW,
    output logic [31:0] Pending,
    output logic        Collision
);

    localparam logic [4:0] ZERO_REG = 5'd31;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    logic w_a_live;
    logic w_b_live;
    logic w_conflict;
    logic w_b_wins;
    logic w_grant_a;
    logic w_grant_b;

    assign w_a_live   = AValid && (ARW != ZERO_REG);
    assign w_b_live   = BValid && (BRW != ZERO_REG);
    assign w_conflict = w_a_live && w_b_live;

    generate
        if (FAIR != 0) begin : g_round_robin
            // Set when the most recent conflict went to A, so B takes the next one.
            logic r_rr_b;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_rr_b <= 1'b0;
                end else if (w_conflict) begin
                    r_rr_b <= w_grant_a;
                end
            end

            assign w_b_wins = r_rr_b;
        end else begin : g_fixed_priority
            logic [3:0] r_starve;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_starve <= 4'd0;
                end else if (w_b_live && !w_grant_b) begin
                    if (r_starve != LIMIT) begin
                        r_starve <= r_starve + 4'd1;
                    end
                end else begin
                    r_starve <= 4'd0;
                end
            end

            assign w_b_wins = (r_starve == LIMIT);
        end
    endgenerate

    assign w_grant_a = w_a_live && (!w_b_live || !w_b_wins);
    assign w_grant_b = w_b_live && (!w_a_live ||  w_b_wins);

    // Ready is masked by reset so both requesters see a stall while Reset_n is low.
    assign AReady = Reset_n && AValid && ((ARW == ZERO_REG) || w_grant_a);
    assign BReady = Reset_n && BValid && ((BRW == ZERO_REG) || w_grant_b);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWr     <= 1'b0;
            RW        <= 5'd0;
            BusW      <= 64'd0;
            Collision <= 1'b0;
        end else begin
            RegWr     <= w_grant_a || w_grant_b;
            Collision <= w_conflict;
            if (w_grant_a) begin
                RW   <= ARW;
                BusW <= ABusW;
            end else if (w_grant_b) begin
                RW   <= BRW;
                BusW <= BBusW;
            end
        end
    end

    always_comb begin
        Pending = 32'd0;
        if (RegWr) begin
            Pending[RW] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Drives one round-robin and one fixed-priority arbiter with identical vectors and
// checks both against a behavioural model every cycle, plus hand-computed checkpoints.
module tb_regwrite_arbiter;

    localparam int LIM_FP = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        AValid = 1'b0, BValid = 1'b0;
    logic [4:0]  ARW = '0, BRW = '0;
    logic [63:0] ABusW = '0, BBusW = '0;

    logic        ard [2];
    logic        brd [2];
    logic        rwr [2];
    logic        col [2];
    logic [4:0]  rw  [2];
    logic [63:0] busw[2];
    logic [31:0] pend[2];

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    regwrite_arbiter #(.FAIR(1), .STARVE_LIMIT(4)) dut_rr (
        .Clk(Clk), .Reset_n(Reset_n),
        .AValid(AValid), .AReady(ard[0]), .ARW(ARW), .ABusW(ABusW),
        .BValid(BValid), .BReady(brd[0]), .BRW(BRW), .BBusW(BBusW),
        .RegWr(rwr[0]), .RW(rw[0]), .BusW(busw[0]), .Pending(pend[0]), .Collision(col[0])
    );

    regwrite_arbiter #(.FAIR(0), .STARVE_LIMIT(LIM_FP)) dut_fp (
        .Clk(Clk), .Reset_n(Reset_n),
        .AValid(AValid), .AReady(ard[1]), .ARW(ARW), .ABusW(ABusW),
        .BValid(BValid), .BReady(brd[1]), .BRW(BRW), .BBusW(BBusW),
        .RegWr(rwr[1]), .RW(rw[1]), .BusW(busw[1]), .Pending(pend[1]), .Collision(col[1])
    );

    // Model state: index 0 = round-robin arbiter, index 1 = fixed priority arbiter.
    bit          m_last_conf_a[2];
    int          m_lost[2];
    bit          m_wr[2];
    logic [4:0]  m_rw[2];
    logic [63:0] m_bus[2];
    bit          m_col[2];

    logic        a_live, b_live, both_live;
    logic [1:0]  g_now[2];   // {grant A, grant B}

    function automatic logic [1:0] winner(int d, logic al, logic bl);
        bit b_takes;
        if (al && bl) begin
            if (d == 0) b_takes = m_last_conf_a[0];
            else        b_takes = (m_lost[1] >= LIM_FP);
            return b_takes ? 2'b01 : 2'b10;
        end
        return {al, bl};
    endfunction

    always_comb begin
        a_live    = AValid && (ARW != 5'd31);
        b_live    = BValid && (BRW != 5'd31);
        both_live = a_live && b_live;
        g_now[0]  = winner(0, a_live, b_live);
        g_now[1]  = winner(1, a_live, b_live);
    end

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int d = 0; d < 2; d++) begin
                m_last_conf_a[d] <= 1'b0;
                m_lost[d]        <= 0;
                m_wr[d]          <= 1'b0;
                m_rw[d]          <= '0;
                m_bus[d]         <= '0;
                m_col[d]         <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_wr[d]  <= |g_now[d];
                m_col[d] <= both_live;
                if (both_live) m_last_conf_a[d] <= g_now[d][1];
                if (b_live && !g_now[d][0])
                    m_lost[d] <= (m_lost[d] + 1 > LIM_FP) ? LIM_FP : m_lost[d] + 1;
                else
                    m_lost[d] <= 0;
                if (g_now[d][1]) begin
                    m_rw[d]  <= ARW;
                    m_bus[d] <= ABusW;
                end else if (g_now[d][0]) begin
                    m_rw[d]  <= BRW;
                    m_bus[d] <= BBusW;
                end
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        e_ar, e_br;
            logic [31:0] e_pend;
            e_ar   = Reset_n && AValid && ((ARW == 5'd31) || g_now[d][1]);
            e_br   = Reset_n && BValid && ((BRW == 5'd31) || g_now[d][0]);
            e_pend = m_wr[d] ? (32'd1 << m_rw[d]) : 32'd0;
            chk($sformatf("model.AReady[%0d]", d), 64'(ard[d]), 64'(e_ar));
            chk($sformatf("model.BReady[%0d]", d), 64'(brd[d]), 64'(e_br));
            chk($sformatf("model.RegWr[%0d]", d), 64'(rwr[d]), 64'(m_wr[d]));
            chk($sformatf("model.RW[%0d]", d), 64'(rw[d]), 64'(m_rw[d]));
            chk($sformatf("model.BusW[%0d]", d), busw[d], m_bus[d]);
            chk($sformatf("model.Pending[%0d]", d), 64'(pend[d]), 64'(e_pend));
            chk($sformatf("model.Collision[%0d]", d), 64'(col[d]), 64'(m_col[d]));
        end
    end

    task automatic drive(logic av, logic [4:0] ar, logic [63:0] ad,
                         logic bv, logic [4:0] br, logic [63:0] bd);
        @(posedge Clk);
        #1;
        AValid = av; ARW = ar; ABusW = ad;
        BValid = bv; BRW = br; BBusW = bd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    typedef struct {
        logic av; logic [4:0] ar; logic [63:0] ad;
        logic bv; logic [4:0] br; logic [63:0] bd;
    } vec_t;

    vec_t misc[8] = '{
        '{1'b0, 5'd0,  64'h0,    1'b1, 5'd14, 64'h1400},
        '{1'b1, 5'd31, 64'hFF,   1'b1, 5'd31, 64'hEE},
        '{1'b1, 5'd31, 64'h31,   1'b1, 5'd0,  64'hB000},
        '{1'b1, 5'd6,  64'h600,  1'b1, 5'd8,  64'h800},
        '{1'b1, 5'd6,  64'h601,  1'b1, 5'd8,  64'h800},
        '{1'b1, 5'd6,  64'h602,  1'b1, 5'd8,  64'h800},
        '{1'b1, 5'd0,  64'hC0DE, 1'b0, 5'd3,  64'h3},
        '{1'b1, 5'd30, 64'h3030, 1'b1, 5'd31, 64'h0}
    };

    bit exp_rr_a2[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit exp_fp_a2[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit exp_rr_a3[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit exp_fp_b3[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset state, with a request presented to prove Ready stays low.
        AValid = 1'b1; ARW = 5'd3; ABusW = 64'h3;
        repeat (2) @(posedge Clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset.RegWr[%0d]", d), 64'(rwr[d]), 64'd0);
            chk($sformatf("reset.Pending[%0d]", d), 64'(pend[d]), 64'd0);
            chk($sformatf("reset.AReady[%0d]", d), 64'(ard[d]), 64'd0);
            chk($sformatf("reset.BusW[%0d]", d), busw[d], 64'd0);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        AValid  = 1'b0;

        // A alone.
        drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        #2 chk("a_only.AReady", 64'(ard[0]), 64'd1);
        idle();
        #2;
        chk("a_only.RegWr", 64'(rwr[0]), 64'd1);
        chk("a_only.RW", 64'(rw[0]), 64'd5);
        chk("a_only.BusW", busw[0], 64'h1234);
        chk("a_only.Pending", 64'(pend[0]), 64'h20);

        // Four conflict cycles: round robin alternates, fixed priority starves B twice.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 64'hA1, 1'b1, 5'd2, 64'hB2);
            #2;
            chk($sformatf("rr4.AReady[%0d]", i), 64'(ard[0]), 64'(exp_rr_a2[i]));
            chk($sformatf("fp4.AReady[%0d]", i), 64'(ard[1]), 64'(exp_fp_a2[i]));
            if (i > 0) begin
                chk($sformatf("rr4.Collision[%0d]", i), 64'(col[0]), 64'd1);
                chk($sformatf("rr4.RegWr[%0d]", i), 64'(rwr[0]), 64'd1);
            end
        end
        idle();
        #2;
        chk("rr4.last.Collision", 64'(col[0]), 64'd1);
        chk("rr4.last.RW", 64'(rw[0]), 64'd2);

        // Six conflict cycles: fixed priority with limit 2 gives A, A, B, A, A, B.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'd1, 64'hA1, 1'b1, 5'd2, 64'hB2);
            #2;
            chk($sformatf("fp6.BReady[%0d]", i), 64'(brd[1]), 64'(exp_fp_b3[i]));
            chk($sformatf("rr6.AReady[%0d]", i), 64'(ard[0]), 64'(exp_rr_a3[i]));
        end
        idle();

        // Zero-register request alongside a live one.
        drive(1'b1, 5'd31, 64'hDEAD, 1'b1, 5'd7, 64'h77);
        #2;
        chk("zero.AReady", 64'(ard[0]), 64'd1);
        chk("zero.BReady", 64'(brd[0]), 64'd1);
        idle();
        #2;
        chk("zero.RegWr", 64'(rwr[0]), 64'd1);
        chk("zero.RW", 64'(rw[0]), 64'd7);
        chk("zero.Collision", 64'(col[0]), 64'd0);

        // Same destination from both, fresh from reset: A's value then B's value.
        @(posedge Clk); #1 Reset_n = 1'b0;
        @(posedge Clk); #1 Reset_n = 1'b1;
        drive(1'b1, 5'd9, 64'hAA, 1'b1, 5'd9, 64'hBB);
        #2;
        chk("same.AReady", 64'(ard[0]), 64'd1);
        chk("same.BReady0", 64'(brd[0]), 64'd0);
        drive(1'b0, 5'd9, 64'hAA, 1'b1, 5'd9, 64'hBB);
        #2;
        chk("same.BReady1", 64'(brd[0]), 64'd1);
        chk("same.first.BusW", busw[0], 64'hAA);
        chk("same.first.RW", 64'(rw[0]), 64'd9);
        idle();
        #2;
        chk("same.second.BusW", busw[0], 64'hBB);
        chk("same.second.RegWr", 64'(rwr[0]), 64'd1);
        idle();
        #2;
        chk("same.hold.RegWr", 64'(rwr[0]), 64'd0);
        chk("same.hold.BusW", busw[0], 64'hBB);

        // Asynchronous reset while a write sits in the output stage.
        drive(1'b1, 5'd12, 64'h5555, 1'b0, 5'd0, 64'd0);
        drive(1'b1, 5'd12, 64'h5556, 1'b0, 5'd0, 64'd0);
        #2;
        chk("areset.before.RegWr", 64'(rwr[0]), 64'd1);
        Reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("areset.RegWr[%0d]", d), 64'(rwr[d]), 64'd0);
            chk($sformatf("areset.Pending[%0d]", d), 64'(pend[d]), 64'd0);
            chk($sformatf("areset.AReady[%0d]", d), 64'(ard[d]), 64'd0);
        end
        @(posedge Clk); #1 Reset_n = 1'b1;
        drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
        #2;
        chk("areset.conflict.AReady", 64'(ard[0]), 64'd1);
        chk("areset.conflict.BReady", 64'(brd[0]), 64'd0);

        // Assorted vectors left to the per-cycle model.
        foreach (misc[i])
            drive(misc[i].av, misc[i].ar, misc[i].ad, misc[i].bv, misc[i].br, misc[i].bd);
        repeat (3) idle();
        @(posedge Clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1, meaning 1 = round-robin and 0 = fixed priority to requester A with starvation guard.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, range 1..15, meaning the number of consecutive losing cycles for B before B is forced a grant (used only when FAIR=0).
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port AValid  input  1  requester A (ALU writeback) has a write.
REQ-006 SHALL have port AReady  output  1  A write accepted this cycle (combinational).
REQ-007 SHALL have port ARW  input  5  A destination register.
REQ-008 SHALL have port ABusW  input  64  A write data.
REQ-009 SHALL have ports BValid, BReady, BRW, BBusW with the same directions and widths, for requester B (load writeback).
REQ-010 SHALL have port RegWr  output  1  registered write enable to the register file.
REQ-011 SHALL have port RW  output  5  registered write address.
REQ-012 SHALL have port BusW  output  64  registered write data.
REQ-013 SHALL have port Pending  output  32  one-hot register currently being written; equals (1<<RW) when RegWr=1, else 0.
REQ-014 SHALL have port Collision  output  1  registered one-cycle pulse when both requesters competed for the port.

Function
REQ-015 Handshake: a write SHALL transfer on a posedge where XValid=1 and XReady=1; requesters hold Valid/RW/BusW stable until Ready.
REQ-016 Zero register: a request with RW=31 SHALL be accepted (Ready=1) in the same cycle it is valid, SHALL NOT use the port, and SHALL NOT assert RegWr.
REQ-017 A "live" request SHALL be Valid=1 with RW!=31; at most one live request SHALL be granted per cycle.
REQ-018 A single live request SHALL be granted immediately.
REQ-019 Two live requests SHALL be a conflict; the winner gets Ready=1, the loser Ready=0; Collision SHALL be 1 in the following cycle.
REQ-020 FAIR=1: a conflict SHALL be granted to the requester not granted at the most recent conflict; the first conflict after reset SHALL go to A.
REQ-021 FAIR=0: a conflict SHALL go to A unless the starve counter equals STARVE_LIMIT, in which case it SHALL go to B.
REQ-022 Starve counter (4-bit): SHALL increment on each cycle B is live and not granted, saturate at STARVE_LIMIT, and clear on a B grant or when B is not live.
REQ-023 Latency: a live grant at posedge k SHALL drive RegWr=1 with RW/BusW equal to the granted request for exactly the cycle following k.
REQ-024 RegWr SHALL be 0 in any cycle after a posedge with no live grant; RW/BusW SHALL hold their previous values.
REQ-025 Same destination from both requesters in one conflict: the writes SHALL be issued on consecutive cycles in grant order, so the loser's data is the final value.
REQ-026 One live request plus one RW=31 request in the same cycle: both SHALL be accepted, and only the live one forwarded.
REQ-027 The arbiter SHALL provide no buffering beyond the single output stage and SHALL accept a new grant every cycle.

Reset
REQ-028 While Reset_n=0: RegWr=0, RW=0, BusW=0, Pending=0, Collision=0, AReady=0, BReady=0; the round-robin pointer SHALL favour A and the starve counter SHALL be 0.
REQ-029 Reset asserted mid-write SHALL discard the write in the output stage immediately (RegWr drops asynchronously); unaccepted requests are not retained.
REQ-030 The first grant SHALL be possible on the first posedge after Reset_n rises.

Verification
REQ-031 A only: AValid=1, ARW=5, ABusW=0x1234 -> AReady=1; next cycle RegWr=1, RW=5, BusW=0x1234, Pending=0x00000020.
REQ-032 FAIR=1, both live for 4 cycles (A: RW=1, B: RW=2) -> grants A, B, A, B; Collision=1 each following cycle; RegWr continuously 1.
REQ-033 FAIR=0, STARVE_LIMIT=2, A and B live continuously -> grants A, A, B, A, A, B.
REQ-034 ARW=31 and BRW=7 together -> AReady=1 and BReady=1 same cycle; next cycle RegWr=1, RW=7, Collision=0.
REQ-035 A and B both target RW=9 (A=0xAA, B=0xBB), FAIR=1 from reset -> RW=9/0xAA then RW=9/0xBB on consecutive cycles.
REQ-036 Reset_n pulled low while RegWr=1 -> RegWr, Pending and Ready outputs go to 0 without waiting for a clock edge; after release, a fresh conflict goes to A.
